// File: rtl/sop_mac_pipe.sv
// sop_mac_pipe: pipelined TAPS-lane sum-of-products with a writable coefficient file,
// valid handshake and saturating accumulate mode with a sticky overflow flag.
module sop_mac_pipe #(
  parameter int WIDTH = 4,
  parameter int TAPS  = 4,
  parameter int SUM_W = 2*WIDTH+$clog2(TAPS),
  parameter int ACC_W = SUM_W+4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [WIDTH-1:0]        coef_wdata,
  input  logic                    in_valid,
  input  logic [TAPS*WIDTH-1:0]   in_data,
  input  logic                    in_mode,
  input  logic                    in_clr,
  output logic                    out_valid,
  output logic [ACC_W-1:0]        out_sum,
  output logic                    overflow
);
  localparam int K = $clog2(TAPS);
  logic [WIDTH-1:0]      coef_q [TAPS];
  logic [TAPS*WIDTH-1:0] data_q, cs_q;
  logic [SUM_W-1:0]      lvl_q [K+1][TAPS];
  logic [K+1:0]          vld_q, mode_q, clr_q;
  logic [ACC_W-1:0]      acc_q, acc_d, sum_ext;
  logic [ACC_W:0]        t;
  logic                  ovf_q, ovf_d, out_valid_q, restart;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
    end else if (coef_we) begin
      coef_q[coef_addr] <= coef_wdata;
    end
  end
  // The input stage snapshots the coefficients, so a same-cycle write only affects later samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      mode_q <= '0;
      clr_q  <= '0;
      data_q <= '0;
      cs_q   <= '0;
      for (int l = 0; l <= K; l++)
        for (int i = 0; i < TAPS; i++) lvl_q[l][i] <= '0;
    end else begin
      vld_q  <= {vld_q[K:0], in_valid};
      mode_q <= {mode_q[K:0], in_mode};
      clr_q  <= {clr_q[K:0], in_clr};
      data_q <= in_data;
      for (int i = 0; i < TAPS; i++) cs_q[i*WIDTH +: WIDTH] <= coef_q[i];
      for (int i = 0; i < TAPS; i++)
        lvl_q[0][i] <= SUM_W'(data_q[i*WIDTH +: WIDTH] * cs_q[i*WIDTH +: WIDTH]);
      for (int l = 1; l <= K; l++)
        for (int j = 0; j < TAPS; j++)
          lvl_q[l][j] <= (j < (TAPS >> l)) ? lvl_q[l-1][(2*j) % TAPS] + lvl_q[l-1][(2*j+1) % TAPS] : '0;
    end
  end
  always_comb begin
    sum_ext = ACC_W'(lvl_q[K][0]);
    restart = !mode_q[K+1] || clr_q[K+1];
    t       = {1'b0, acc_q} + {1'b0, sum_ext};
    acc_d   = !vld_q[K+1] ? acc_q : restart ? sum_ext : t[ACC_W] ? '1 : t[ACC_W-1:0];
    ovf_d   = !vld_q[K+1] ? ovf_q : restart ? 1'b0 : (ovf_q | t[ACC_W]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= vld_q[K+1];
    end
  end
  assign out_sum   = acc_q;
  assign overflow  = ovf_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_sop_mac_pipe.sv
// tb_sop_mac_pipe: directed stimulus with a queue scoreboard checked by an independent monitor.
module tb_sop_mac_pipe;
  localparam int WIDTH = 4, TAPS = 4, SUM_W = 10, ACC_W = 14, LAT = 4;
  logic                  clk, rst_n, coef_we, in_valid, in_mode, in_clr;
  logic [1:0]            coef_addr;
  logic [WIDTH-1:0]      coef_wdata;
  logic [TAPS*WIDTH-1:0] in_data;
  logic                  out_valid, overflow;
  logic [ACC_W-1:0]      out_sum;
  typedef struct {logic [ACC_W-1:0] sum; logic ovf; int cyc;} exp_t;
  exp_t   q[$];
  int     checks = 0, errors = 0, cyc = 0;
  int     mc[TAPS];
  longint macc;
  bit     movf;
  sop_mac_pipe #(.WIDTH(WIDTH), .TAPS(TAPS), .SUM_W(SUM_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .in_valid(in_valid), .in_data(in_data), .in_mode(in_mode), .in_clr(in_clr),
    .out_valid(out_valid), .out_sum(out_sum), .overflow(overflow)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: sum=%0d ovf=%0b cyc=%0d, expected no out_valid", out_sum, overflow, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (out_sum !== e.sum || overflow !== e.ovf || cyc != e.cyc) begin
          errors++;
          $display("FAIL result: sum=%0d ovf=%0b cyc=%0d, expected sum=%0d ovf=%0b cyc=%0d",
                   out_sum, overflow, cyc, e.sum, e.ovf, e.cyc);
        end
      end
    end
  end
  function automatic logic [TAPS*WIDTH-1:0] pk(input int a, input int b, input int c, input int d);
    logic [3:0] l0 = 4'(a), l1 = 4'(b), l2 = 4'(c), l3 = 4'(d);
    return {l3, l2, l1, l0};
  endfunction
  task automatic step(input bit we, input int addr, input int wd, input bit v,
                      input logic [TAPS*WIDTH-1:0] d, input bit mode, input bit clr);
    @(posedge clk);
    #1;
    coef_we = we; coef_addr = 2'(addr); coef_wdata = 4'(wd);
    in_valid = v; in_data = d; in_mode = mode; in_clr = clr;
    if (v) begin
      longint s = 0;
      for (int i = 0; i < TAPS; i++) s += longint'(d[i*WIDTH +: WIDTH]) * mc[i];
      if (!mode || clr) begin
        macc = s; movf = 0;
      end else begin
        macc += s;
        if (macc > 16383) begin macc = 16383; movf = 1; end
      end
      q.push_back('{sum: ACC_W'(macc), ovf: movf, cyc: cyc + 1 + LAT});
    end
    if (we) mc[addr] = wd;
  endtask
  task automatic sample(input logic [TAPS*WIDTH-1:0] d, input bit mode, input bit clr);
    step(0, 0, 0, 1, d, mode, clr);
  endtask
  task automatic wr4(input int a, input int b, input int c, input int d);
    step(1, 0, a, 0, '0, 0, 0);
    step(1, 1, b, 0, '0, 0, 0);
    step(1, 2, c, 0, '0, 0, 0);
    step(1, 3, d, 0, '0, 0, 0);
  endtask
  task automatic drain();
    int n = 0;
    step(0, 0, 0, 0, '0, 0, 0);
    while (q.size() > 0 && n < 50) begin @(posedge clk); n++; end
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
      q.delete();
    end
    repeat (3) @(posedge clk);
  endtask
  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask
  initial begin
    rst_n = 0; coef_we = 0; coef_addr = 0; coef_wdata = 0;
    in_valid = 0; in_data = 0; in_mode = 0; in_clr = 0;
    for (int i = 0; i < TAPS; i++) mc[i] = 0;
    macc = 0; movf = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("reset_sum", out_sum, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_valid", out_valid, 0);
    wr4(2, 5, 7, 9);
    sample(pk(4, 3, 1, 0), 0, 0);
    drain();
    wr4(15, 15, 15, 15);
    sample(pk(15, 15, 15, 15), 0, 0);
    sample(pk(0, 0, 0, 0), 0, 0);
    wr4(1, 1, 1, 1);
    sample(pk(1, 1, 1, 1), 0, 0);
    drain();
    // back-to-back burst with a coefficient rewrite landing mid-stream
    wr4(2, 5, 7, 9);
    sample(pk(4, 3, 1, 0), 0, 0);
    sample(pk(15, 15, 15, 15), 0, 0);
    sample(pk(0, 0, 0, 0), 0, 0);
    step(1, 3, 4, 1, pk(1, 1, 1, 1), 0, 0);
    sample(pk(8, 3, 2, 4), 0, 0);
    sample(pk(5, 6, 7, 9), 0, 0);
    sample(pk(2, 5, 1, 8), 0, 0);
    sample(pk(9, 10, 11, 12), 0, 0);
    drain();
    wr4(15, 15, 15, 15);
    sample(pk(15, 15, 15, 15), 1, 1);
    for (int i = 0; i < 18; i++) sample(pk(15, 15, 15, 15), 1, 0);
    sample(pk(15, 15, 15, 15), 1, 1);
    drain();
    wr4(2, 5, 7, 9);
    step(1, 0, 1, 1, pk(4, 3, 1, 0), 0, 0);
    sample(pk(4, 3, 1, 0), 0, 0);
    drain();
    sample(pk(3, 3, 3, 3), 0, 0);
    sample(pk(5, 5, 5, 5), 1, 0);
    sample(pk(7, 7, 7, 7), 1, 0);
    @(posedge clk);
    #1;
    rst_n = 0; in_valid = 0; coef_we = 0;
    q.delete();
    for (int i = 0; i < TAPS; i++) mc[i] = 0;
    macc = 0; movf = 0;
    #1;
    chk("midreset_sum", out_sum, 0);
    chk("midreset_ovf", overflow, 0);
    chk("midreset_valid", out_valid, 0);
    @(posedge clk);
    #1 rst_n = 1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_reset_sum", out_sum, 0);
    sample(pk(15, 15, 15, 15), 0, 0);
    drain();
    chk("leftover", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
